// File: rtl/dw_event_driver.sv
// Two-phase event source for a decision-wait element.
// Ports: clk/rstn, cmd_valid/ready/sel in, a1/a2/fire out, z1/z2 in, done_valid/done_sel, err/err_code.
module dw_event_driver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_sel,
  output logic       a1,
  output logic       a2,
  output logic       fire,
  input  logic       z1,
  input  logic       z2,
  output logic       done_valid,
  output logic       done_sel,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    ERR
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] s1, s2;
  logic          zs1, zs2;
  logic          zh1, zh2, zh1_n, zh2_n;
  logic          sel_q, sel_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          a1_n, a2_n, fire_n;
  logic          done_n, dsel_n;
  logic          err_n;
  logic [1:0]    code_n;
  logic          ch1, ch2, exp_ch, oth_ch;

  assign zs1 = s1[SYNC_STAGES-1];
  assign zs2 = s2[SYNC_STAGES-1];

  assign ch1    = zs1 ^ zh1;
  assign ch2    = zs2 ^ zh2;
  assign exp_ch = sel_q ? ch2 : ch1;
  assign oth_ch = sel_q ? ch1 : ch2;

  // Saturating count so a disabled timeout never wraps.
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    a1_n    = a1;
    a2_n    = a2;
    fire_n  = fire;
    sel_n   = sel_q;
    cnt_n   = cnt;
    zh1_n   = zh1;
    zh2_n   = zh2;
    done_n  = 1'b0;
    dsel_n  = done_sel;
    err_n   = err;
    code_n  = err_code;
    case (state)
      IDLE: begin
        if (ch1 | ch2) begin
          state_n = ERR;
          err_n   = 1'b1;
          code_n  = 2'b11;
        end else if (cmd_valid && cmd_ready) begin
          sel_n   = cmd_sel;
          a1_n    = a1 ^ ~cmd_sel;
          a2_n    = a2 ^ cmd_sel;
          cnt_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        fire_n  = ~fire;
        state_n = WAIT;
      end
      WAIT: begin
        if (oth_ch) begin
          // Wrong output, or both at once: report z2 when both moved.
          zh1_n   = zs1;
          zh2_n   = zs2;
          done_n  = 1'b1;
          dsel_n  = ch2;
          err_n   = 1'b1;
          code_n  = 2'b01;
          state_n = ERR;
        end else if (exp_ch) begin
          zh1_n   = zs1;
          zh2_n   = zs2;
          done_n  = 1'b1;
          dsel_n  = sel_q;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == TO) begin
            err_n   = 1'b1;
            code_n  = 2'b10;
            state_n = ERR;
          end
        end
      end
      default: begin
        state_n = ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      s1         <= '0;
      s2         <= '0;
      zh1        <= 1'b0;
      zh2        <= 1'b0;
      sel_q      <= 1'b0;
      cnt        <= '0;
      a1         <= 1'b0;
      a2         <= 1'b0;
      fire       <= 1'b0;
      cmd_ready  <= 1'b0;
      done_valid <= 1'b0;
      done_sel   <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state      <= state_n;
      s1         <= {s1[SYNC_STAGES-2:0], z1};
      s2         <= {s2[SYNC_STAGES-2:0], z2};
      zh1        <= zh1_n;
      zh2        <= zh2_n;
      sel_q      <= sel_n;
      cnt        <= cnt_n;
      a1         <= a1_n;
      a2         <= a2_n;
      fire       <= fire_n;
      cmd_ready  <= (state_n == IDLE);
      done_valid <= done_n;
      done_sel   <= dsel_n;
      err        <= err_n;
      err_code   <= code_n;
    end
  end

endmodule
